adc_spi_capture: RTL

- Upstream front-end for the test sequencer.
- Drives a serial (SPI-style, mode 0) ADC and deserialises 16-bit MSB-first frames.
- Optionally averages 2^AVG_LOG2 frames, then presents the result on adc_data with a one-cycle adc_ready pulse.
- The sequencer consumes adc_data/adc_ready directly in its wait-for-ADC and wait-for-response states.

---
 rtl/adc_spi_capture.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI mode-0 ADC front-end. Frames a 16-bit MSB-first
// conversion under adc_cs_n, optionally averages 2^AVG_LOG2 frames, and
// presents the result on adc_data with a one-cycle adc_ready pulse.
module adc_spi_capture #(
    parameter int CLK_DIV   = 4,
    parameter int CONV_WAIT = 3,
    parameter int AVG_LOG2  = 0,
    parameter int CS_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont_en,
    input  logic        clr_ovr,
    input  logic        adc_sdo,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [15:0] adc_data,
    output logic        adc_ready,
    output logic        busy,
    output logic        overrun,
    output logic [31:0] sample_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONV  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam logic [4:0]  N_FRAMES  = 5'(1 << AVG_LOG2);
    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] CONV_LAST = 32'(CONV_WAIT - 1);
    localparam logic [31:0] GAP_LAST  = 32'(CS_GAP - 1);
    localparam logic [31:0] GAP_SAT   = 32'(CS_GAP);

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_cnt_q, hi_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] acc_q, acc_d;
    logic [4:0]  frame_cnt_q, frame_cnt_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic [15:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        ovr_q, ovr_d;
    logic [31:0] count_q, count_d;
    logic [19:0] acc_sum;
    logic        gap_ok;

    // Next-state and datapath logic for the capture sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        count_d     = count_q;
        acc_sum     = acc_q + {4'b0000, shift_q};

        // hi_cnt counts completed cs_n-high cycles, so a falling edge is
        // legal once the current cycle brings the total up to CS_GAP.
        hi_cnt_d = cs_n_q ? ((hi_cnt_q >= GAP_SAT) ? hi_cnt_q : hi_cnt_q + 32'd1) : '0;
        gap_ok   = (hi_cnt_q >= GAP_LAST);

        if (start && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start || cont_en) begin
                    if (gap_ok) begin
                        state_d = S_CONV;
                        cs_n_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_ok) begin
                    state_d = S_CONV;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d   = S_SHIFT;
                    sclk_d    = 1'b1;
                    shift_d   = {shift_q[14:0], adc_sdo};
                    bit_cnt_d = 5'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == 5'd16) begin
                        state_d = S_ACCUM;
                        cs_n_d  = 1'b1;
                    end else begin
                        sclk_d    = 1'b1;
                        shift_d   = {shift_q[14:0], adc_sdo};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ACCUM: begin
                // The result is latched here so adc_data is already valid
                // during the OUT cycle that carries adc_ready.
                acc_d       = acc_sum;
                frame_cnt_d = frame_cnt_q + 5'd1;
                bit_cnt_d   = '0;
                if (5'(frame_cnt_q + 5'd1) == N_FRAMES) begin
                    state_d = S_OUT;
                    data_d  = 16'(acc_sum >> AVG_LOG2);
                    ready_d = 1'b1;
                    count_d = count_q + 32'd1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_OUT: begin
                acc_d       = '0;
                frame_cnt_d = '0;
                state_d     = cont_en ? S_GAP : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_cnt_q    <= GAP_SAT;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            frame_cnt_q <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            ovr_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            ovr_q       <= ovr_d;
            count_q     <= count_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_data     = data_q;
    assign adc_ready    = ready_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = ovr_q;
    assign sample_count = count_q;

endmodule
